serial_word_feeder: RTL and testbench
=====================================

SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 SHALL have port areset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a parallel word is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 SHALL have port in_data, input, WIDTH bits: the two's-complement operand.
REQ-007 SHALL have port ser_clr, output, 1 bit: one-cycle frame-clear pulse for the downstream serial stage.
REQ-008 SHALL have port ser_valid, output, 1 bit: ser_x carries a data bit.
REQ-009 SHALL have port ser_x, output, 1 bit: serial data, LSB first.
REQ-010 SHALL have port ser_last, output, 1 bit: the current ser_x is bit WIDTH-1.
REQ-011 SHALL have port ser_ready, input, 1 bit, present only with SER_BACKPRESSURE_EN: downstream accepts ser_x.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CLR, SHIFT.
REQ-013 SHALL drive in_ready=1 in IDLE, and also in SHIFT during the cycle where the final bit is accepted; in_ready SHALL be 0 otherwise.
REQ-014 SHALL, on in_valid&&in_ready, load in_data into the shift register, clear the bit counter and go to CLR.
REQ-015 SHALL hold ser_clr=1, ser_valid=0 and ser_x=0 for exactly one cycle in CLR, then go to SHIFT unconditionally.
REQ-016 SHALL, in SHIFT, drive ser_valid=1 and ser_x=shift_reg[0]; on accept, shift right by 1 and increment the counter.
REQ-017 SHALL assert ser_last=1 only in SHIFT with counter==WIDTH-1.
REQ-018 SHALL, on accept of the last bit, go to CLR if in_valid=1 (new word loaded, back-to-back) and to IDLE otherwise.
REQ-019 SHALL have latency: word accepted at edge T gives ser_clr in cycle T+1, bit0 at T+2 and bit WIDTH-1 at T+WIDTH+1; sustained throughput is one word per WIDTH+1 cycles.
REQ-020 SHALL drive ser_x=0, ser_valid=0 and ser_last=0 in IDLE and CLR.
REQ-021 SHALL use a counter of $clog2(WIDTH) bits with no wrap; the terminal value is WIDTH-1.
REQ-022 SHALL ignore in_data changes after load; the word is captured only on acceptance.

Reset
REQ-023 SHALL, while areset_n=0, force IDLE, shift register 0, counter 0, ser_clr=0, ser_valid=0, ser_x=0, ser_last=0 and in_ready=1, asynchronously.
REQ-024 SHALL, on reset mid-word, discard the remainder of that word; the next word starts with a CLR cycle.

Configuration
REQ-025 SHALL, with SER_BACKPRESSURE_EN defined, include the ser_ready port; accept in SHIFT = ser_ready, and ser_x, ser_last and the counter hold while ser_ready=0. ser_clr SHALL be ser_ready-independent.
REQ-026 SHALL, without SER_BACKPRESSURE_EN, omit the ser_ready port and treat accept as constantly 1.

Structure
REQ-027 SHALL place the state enum (IDLE/CLR/SHIFT) and the default WIDTH constant in shared package ser_pkg.
REQ-028 SHALL be a single module with no sub-modules; the downstream serial two's-complement stage consumes ser_x, and its reset is driven from ser_clr.

Verification
REQ-029 SHALL cover: WIDTH=8, in_data=8'h05 accepted at T -> ser_clr at T+1; ser_x=1,0,1,0,0,0,0,0 over T+2..T+9; ser_last only at T+9.
REQ-030 SHALL cover: back-to-back 8'hFF then 8'h80 with in_valid held -> second ser_clr immediately after the first ser_last; second word bits 0,0,0,0,0,0,0,1; no idle gap.
REQ-031 SHALL cover (SER_BACKPRESSURE_EN): 8'hA5 with ser_ready=0 for 3 cycles at bit2 -> ser_x=1 held 4 cycles; ser_last at T+12.
REQ-032 SHALL cover: areset_n pulsed low after bit3 of 8'h3C -> all outputs 0 immediately and in_ready=1; next word 8'h01 produces ser_clr, then bits 1,0,0,0,0,0,0,0.
REQ-033 SHALL cover: in_valid=0 for 20 cycles after reset -> ser_valid=0, ser_clr=0 and in_ready=1 throughout.
REQ-034 SHALL cover: chained with the downstream stage, 8'h05 -> collected output 8'hFB; 8'h80 -> 8'h80.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared FSM state type and default word length for the serial word feeder.
package ser_pkg;

  localparam int unsigned SER_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2
  } ser_state_e;

endpackage

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: LSB first, each word framed by a one-cycle ser_clr pulse.
// Optional SER_BACKPRESSURE_EN adds the ser_ready handshake on the serial side.
module serial_word_feeder
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_clr,
  output logic             ser_valid,
  output logic             ser_x,
  output logic             ser_last
`ifdef SER_BACKPRESSURE_EN
  ,
  input  logic             ser_ready
`endif
);

  localparam int unsigned      CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  ser_state_e       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             final_bit;
  logic             load;

`ifdef SER_BACKPRESSURE_EN
  assign accept = ser_ready;
`else
  assign accept = 1'b1;
`endif

  // A new word may be taken in the same cycle the previous word's last bit leaves.
  assign final_bit = (state == SHIFT) && (cnt == LAST) && accept;
  assign in_ready  = (state == IDLE) || final_bit;
  assign load      = in_valid && in_ready;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      ser_clr   <= 1'b0;
      ser_valid <= 1'b0;
      ser_x     <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      ser_clr   <= 1'b0;
      ser_valid <= 1'b0;
      ser_x     <= 1'b0;
      ser_last  <= 1'b0;
      if (load) begin
        state     <= CLR;
        shift_reg <= in_data;
        cnt       <= '0;
        ser_clr   <= 1'b1;
      end else begin
        case (state)
          CLR: begin
            state     <= SHIFT;
            ser_valid <= 1'b1;
            ser_x     <= shift_reg[0];
          end
          SHIFT: begin
            if (!accept) begin
              // Downstream stalled: present the same bit again.
              ser_valid <= 1'b1;
              ser_x     <= ser_x;
              ser_last  <= ser_last;
            end else if (cnt == LAST) begin
              state <= IDLE;
            end else begin
              shift_reg <= shift_reg >> 1;
              cnt       <= cnt + CNT_W'(1);
              ser_valid <= 1'b1;
              ser_x     <= shift_reg[1];
              ser_last  <= ((cnt + CNT_W'(1)) == LAST);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Self-checking bench for serial_word_feeder: directed scenarios plus random traffic
// against a queue-based output-stream model and a serial two's-complement collector.
module tb_serial_word_feeder;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic clr;
    logic x;
    logic last;
  } ev_t;

  logic         clk = 1'b0;
  logic         areset_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         ser_clr;
  logic         ser_valid;
  logic         ser_x;
  logic         ser_last;
`ifdef SER_BACKPRESSURE_EN
  logic         ser_ready;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ev_t          q[$];
  logic [W-1:0] want_q[$];
  logic [W-1:0] got_q[$];

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ser_clr   (ser_clr),
    .ser_valid (ser_valid),
    .ser_x     (ser_x),
    .ser_last  (ser_last)
`ifdef SER_BACKPRESSURE_EN
    ,
    .ser_ready (ser_ready)
`endif
  );

  function automatic logic acc_now();
`ifdef SER_BACKPRESSURE_EN
    return ser_ready;
`else
    return 1'b1;
`endif
  endfunction

  // Ready when nothing is pending, or only the final bit remains and it leaves now.
  function automatic logic model_ready();
    return (q.size() == 0) || (q.size() == 1 && acc_now());
  endfunction

  function automatic logic [3:0] exp_out();
    if (q.size() == 0) return 4'b0000;
    return {q[0].clr, !q[0].clr, q[0].x, q[0].last};
  endfunction

  // Output-stream model: each accepted word appends one clear slot and W bit slots.
  always @(posedge clk or negedge areset_n) begin : model
    logic         r;
    logic [W-1:0] neg;
    if (!areset_n) begin
      q.delete();
      want_q.delete();
    end else begin
      r = model_ready();
      if (q.size() > 0 && (q[0].clr || acc_now())) void'(q.pop_front());
      if (r && in_valid) begin
        q.push_back(ev_t'{1'b1, 1'b0, 1'b0});
        for (int i = 0; i < int'(W); i++)
          q.push_back(ev_t'{1'b0, in_data[i], (i == int'(W) - 1)});
        neg = ~in_data + 1'b1;
        want_q.push_back(neg);
      end
    end
  end

  // Downstream serial negator: copy bits up to the first 1, invert after; cleared by ser_clr.
  always @(posedge clk or negedge areset_n) begin : collector
    logic         seen1;
    int           idx;
    logic [W-1:0] col;
    if (!areset_n) begin
      seen1 = 1'b0;
      idx   = 0;
      col   = '0;
      got_q.delete();
    end else if (ser_clr) begin
      seen1 = 1'b0;
      idx   = 0;
      col   = '0;
    end else if (ser_valid && acc_now()) begin
      col[idx] = ser_x ^ seen1;
      seen1    = seen1 | ser_x;
      idx++;
      if (ser_last) got_q.push_back(col);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef SER_BACKPRESSURE_EN
    ser_ready = 1'b1;
`endif
    #12;
    n_tests++;
    if ({ser_clr, ser_valid, ser_x, ser_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000", {ser_clr, ser_valid, ser_x, ser_last});
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    areset_n = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_idle();
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_data = W'($urandom);
      tick();
      n_tests++;
      if ({ser_valid, ser_clr, in_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: valid/clr/ready got %b want 001", c, {ser_valid, ser_clr, in_ready});
      end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] bits;
    bits     = 8'h05;
    in_valid = 1'b1;
    in_data  = 8'h05;
    tick();
    n_tests++;
    if ({ser_clr, ser_valid, ser_x, ser_last, in_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL single_clr: clr/valid/x/last/ready got %b want 10000",
               {ser_clr, ser_valid, ser_x, ser_last, in_ready});
    end
    in_valid = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      in_data = W'($urandom);
      tick();
      n_tests++;
      if ({ser_clr, ser_valid, ser_x, ser_last, in_ready} !==
          {1'b0, 1'b1, bits[i], (i == int'(W) - 1), (i == int'(W) - 1)}) begin
        n_fail++;
        $display("FAIL single_bit%0d: clr/valid/x/last/ready got %b want %b", i,
                 {ser_clr, ser_valid, ser_x, ser_last, in_ready},
                 {1'b0, 1'b1, bits[i], (i == int'(W) - 1), (i == int'(W) - 1)});
      end
    end
    tick();
    n_tests++;
    if ({ser_clr, ser_valid, ser_x, ser_last, in_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL single_idle: got %b want 00001", {ser_clr, ser_valid, ser_x, ser_last, in_ready});
    end
    n_tests++;
    if (got_q.size() == 0 || got_q[$] !== 8'hFB) begin
      n_fail++;
      $display("FAIL chain_05: got %h want fb", got_q.size() ? got_q[$] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] b2;
    b2       = 8'h80;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    n_tests++;
    if ({ser_clr, ser_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_clr1: clr/valid got %b want 10", {ser_clr, ser_valid});
    end
    in_data = 8'h80;
    for (int i = 0; i < int'(W); i++) begin
      tick();
      n_tests++;
      if ({ser_clr, ser_valid, ser_x, ser_last, in_ready} !==
          {1'b0, 1'b1, 1'b1, (i == int'(W) - 1), (i == int'(W) - 1)}) begin
        n_fail++;
        $display("FAIL b2b_w1_bit%0d: clr/valid/x/last/ready got %b", i,
                 {ser_clr, ser_valid, ser_x, ser_last, in_ready});
      end
    end
    tick();
    n_tests++;
    if ({ser_clr, ser_valid, ser_x, ser_last} !== 4'b1000) begin
      n_fail++;
      $display("FAIL b2b_clr2_no_gap: got %b want 1000", {ser_clr, ser_valid, ser_x, ser_last});
    end
    in_valid = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      in_data = W'($urandom);
      tick();
      n_tests++;
      if ({ser_valid, ser_x, ser_last} !== {1'b1, b2[i], (i == int'(W) - 1)}) begin
        n_fail++;
        $display("FAIL b2b_w2_bit%0d: valid/x/last got %b want %b", i,
                 {ser_valid, ser_x, ser_last}, {1'b1, b2[i], (i == int'(W) - 1)});
      end
    end
    tick();
    n_tests++;
    if (got_q.size() < 2 || got_q[$-1] !== 8'h01 || got_q[$] !== 8'h80) begin
      n_fail++;
      $display("FAIL chain_ff_80: got %0d words, last %h want 01 then 80",
               got_q.size(), got_q.size() ? got_q[$] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] bits;
    bits     = 8'h3C;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({ser_valid, ser_x} !== {1'b1, bits[i]}) begin
        n_fail++;
        $display("FAIL rst_mid_bit%0d: valid/x got %b want %b", i, {ser_valid, ser_x}, {1'b1, bits[i]});
      end
    end
    #2 areset_n = 1'b0;
    #1;
    n_tests++;
    if ({ser_clr, ser_valid, ser_x, ser_last, in_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL rst_mid_async: clr/valid/x/last/ready got %b want 00001",
               {ser_clr, ser_valid, ser_x, ser_last, in_ready});
    end
    @(negedge clk);
    areset_n = 1'b1;
    bits     = 8'h01;
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    n_tests++;
    if ({ser_clr, ser_valid, ser_x} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_mid_new_clr: clr/valid/x got %b want 100", {ser_clr, ser_valid, ser_x});
    end
    in_valid = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      tick();
      n_tests++;
      if ({ser_valid, ser_x, ser_last} !== {1'b1, bits[i], (i == int'(W) - 1)}) begin
        n_fail++;
        $display("FAIL rst_mid_new_bit%0d: valid/x/last got %b", i, {ser_valid, ser_x, ser_last});
      end
    end
    tick();
    n_tests++;
    if (got_q.size() != 1 || got_q[0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL chain_after_reset: got %0d words, first %h want 1 word ff",
               got_q.size(), got_q.size() ? got_q[0] : 8'hxx);
    end
  endtask

`ifdef SER_BACKPRESSURE_EN
  task automatic test_backpressure();
    logic [3:0] tab [12];
    tab = '{4'b1000, 4'b0110, 4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0110,
            4'b0100, 4'b0100, 4'b0110, 4'b0100, 4'b0111};
    ser_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      ser_ready = !(k >= 4 && k <= 6);
      #1;
      n_tests++;
      if ({ser_clr, ser_valid, ser_x, ser_last} !== tab[k-1]) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: clr/valid/x/last got %b want %b", k,
                 {ser_clr, ser_valid, ser_x, ser_last}, tab[k-1]);
      end
      n_tests++;
      if (in_ready !== (k == 12)) begin
        n_fail++;
        $display("FAIL bp_ready%0d: got %b want %b", k, in_ready, (k == 12));
      end
      tick();
    end
    n_tests++;
    if (got_q.size() == 0 || got_q[$] !== 8'h5B) begin
      n_fail++;
      $display("FAIL chain_a5: got %h want 5b", got_q.size() ? got_q[$] : 8'hxx);
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
`ifdef SER_BACKPRESSURE_EN
      ser_ready = ($urandom_range(0, 3) != 0);
`endif
      #1;
      n_tests++;
      if (in_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL rand_ready%0d: got %b want %b", c, in_ready, model_ready());
      end
      tick();
      n_tests++;
      if ({ser_clr, ser_valid, ser_x, ser_last} !== exp_out()) begin
        n_fail++;
        $display("FAIL rand_out%0d: clr/valid/x/last got %b want %b", c,
                 {ser_clr, ser_valid, ser_x, ser_last}, exp_out());
      end
    end
    in_valid = 1'b0;
`ifdef SER_BACKPRESSURE_EN
    ser_ready = 1'b1;
`endif
    for (int c = 0; c < 12; c++) begin
      tick();
      n_tests++;
      if ({ser_clr, ser_valid, ser_x, ser_last} !== exp_out()) begin
        n_fail++;
        $display("FAIL rand_drain%0d: got %b want %b", c,
                 {ser_clr, ser_valid, ser_x, ser_last}, exp_out());
      end
    end
    n_tests++;
    if (got_q.size() != want_q.size()) begin
      n_fail++;
      $display("FAIL rand_chain_count: got %0d words want %0d", got_q.size(), want_q.size());
    end else begin
      for (int i = 0; i < got_q.size(); i++) begin
        n_tests++;
        if (got_q[i] !== want_q[i]) begin
          n_fail++;
          $display("FAIL rand_chain_word%0d: got %h want %h", i, got_q[i], want_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_reset_mid();
`ifdef SER_BACKPRESSURE_EN
    test_backpressure();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
